// File: rtl/nor23.sv
// Bitwise NOR datapath with a registered monitor that captures the result,
// its population count and a saturating count of result changes.
module nor23 #(
    parameter int unsigned WIDTH = 23,
    parameter int unsigned CNT_W = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [WIDTH-1:0]               a_i,
    input  logic [WIDTH-1:0]               b_i,
    output logic [WIDTH-1:0]               c_o,
    output logic [WIDTH-1:0]               c_q_o,
    output logic [$clog2(WIDTH+1)-1:0]     ones_o,
    output logic [CNT_W-1:0]               chg_cnt_o
);

    localparam int unsigned ONES_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  c_q, c_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0]  chg_cnt_q, chg_cnt_d;

    assign c_o = ~(a_i | b_i);

    always_comb begin
        c_d    = c_o;
        ones_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones_d = ones_d + ONES_W'(c_o[i]);
        end
        chg_cnt_d = chg_cnt_q;
        // Saturate rather than wrap so a long-running debug count stays meaningful.
        if ((c_o != c_q) && (chg_cnt_q != '1)) begin
            chg_cnt_d = chg_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            c_q       <= '0;
            ones_q    <= '0;
            chg_cnt_q <= '0;
        end else begin
            c_q       <= c_d;
            ones_q    <= ones_d;
            chg_cnt_q <= chg_cnt_d;
        end
    end

    assign c_q_o     = c_q;
    assign ones_o    = ones_q;
    assign chg_cnt_o = chg_cnt_q;

endmodule

// File: tb/tb_nor23.sv
// Directed self-checking bench for nor23: combinational corners, random stress,
// reset, monitor latency, counter saturation and mid-operation reset.
`timescale 1ns/1ps
module tb_nor23;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [22:0] a, b;
    logic [22:0] c, c_q;
    logic [4:0]  ones;
    logic [15:0] chg_cnt;

    int checks;
    int errors;

    nor23 #(.WIDTH(23), .CNT_W(16)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .a_i       (a),
        .b_i       (b),
        .c_o       (c),
        .c_q_o     (c_q),
        .ones_o    (ones),
        .chg_cnt_o (chg_cnt)
    );

    // Clock is held idle during the purely combinational phases.
    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mon(input string tag, input logic [22:0] exp_cq,
                           input logic [4:0] exp_ones, input logic [15:0] exp_cnt);
        chk({tag, "_cq"},   32'(c_q),     32'(exp_cq));
        chk({tag, "_ones"}, 32'(ones),    32'(exp_ones));
        chk({tag, "_cnt"},  32'(chg_cnt), 32'(exp_cnt));
    endtask

    initial begin
        logic [22:0] exp_c;
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        a      = '0;
        b      = '0;

        // Combinational corners
        a = 23'h000000; b = 23'h000000; #1; chk("corner_zero",  32'(c), 32'h7FFFFF);
        a = 23'h7FFFFF; b = 23'h000000; #1; chk("corner_ones",  32'(c), 32'h000000);
        a = 23'h555555; b = 23'h2AAAAA; #1; chk("corner_alt",   32'(c), 32'h000000);
        a = 23'h400000; b = 23'h000001; #1; chk("corner_edges", 32'(c), 32'h3FFFFE);

        // Random stress
        for (int i = 0; i < 10000; i++) begin
            a = 23'({$random} % (1 << 23));
            b = 23'({$random} % (1 << 23));
            exp_c = ~(a | b);
            #1;
            chk("rand_c", 32'(c), 32'(exp_c));
        end

        // Reset held for two edges
        a = '0; b = '0; rst_n = 1'b0;
        #1;
        clk_en = 1'b1;
        tick();
        chk_mon("rst1", 23'h0, 5'd0, 16'd0);
        chk("rst1_c", 32'(c), 32'h7FFFFF);
        tick();
        chk_mon("rst2", 23'h0, 5'd0, 16'd0);
        chk("rst2_c", 32'(c), 32'h7FFFFF);

        // Monitor latency
        rst_n = 1'b1;
        tick();
        chk_mon("lat1", 23'h7FFFFF, 5'd23, 16'd1);
        a = 23'h000001;
        tick();
        chk_mon("lat2", 23'h7FFFFE, 5'd22, 16'd2);
        tick();
        tick();
        chk_mon("hold", 23'h7FFFFE, 5'd22, 16'd2);

        // Mid-operation reset while inputs toggle
        a = 23'h000000; rst_n = 1'b0;
        tick();
        chk_mon("midrst", 23'h0, 5'd0, 16'd0);
        chk("midrst_c", 32'(c), 32'h7FFFFF);
        a = 23'h000001; rst_n = 1'b1;
        tick();
        chk_mon("resume1", 23'h7FFFFE, 5'd22, 16'd1);
        a = 23'h000000;
        tick();
        chk_mon("resume2", 23'h7FFFFF, 5'd23, 16'd2);

        // Saturation: every toggle is a change; count 2 -> 0xFFFE -> 0xFFFF
        for (int i = 0; i < 65532; i++) begin
            a = a ^ 23'h000001;
            tick();
        end
        chk("sat_pre", 32'(chg_cnt), 32'h0000FFFE);
        a = a ^ 23'h000001;
        tick();
        chk("sat_hit", 32'(chg_cnt), 32'h0000FFFF);
        for (int i = 0; i < 4; i++) begin
            a = a ^ 23'h000001;
            tick();
            chk("sat_hold", 32'(chg_cnt), 32'h0000FFFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
